fdiv_round_pack: RTL and testbench

//  Post-divide stage of the FPU single-precision divide path. Captures the 1.31 fixed-point

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fdiv_rshift_jam.sv | 23 ++
 rtl/fdiv_round_pack.sv | 195 +++++++++++++++++++
 tb/tb_fdiv_round_pack.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the single-precision FPU divide path: rounding modes,
// operand special classes, fflags bit positions and canonical constants.
package fpu_pkg;

    localparam int EXP_W     = 10;
    localparam int SHIFT_CAP = 26;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'b00,
        SP_NAN    = 2'b01,
        SP_INF    = 2'b10,
        SP_ZERO   = 2'b11
    } special_e;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} fflags vector
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
    localparam logic [30:0] MAX_MAG   = 31'h7F7F_FFFF;

    // Reserved rm encodings 5-7 fall back to round-to-nearest-even
    function automatic logic [2:0] rm_legal(input logic [2:0] rm);
        return (rm > RM_RMM) ? RM_RNE : rm;
    endfunction

endpackage

// File: rtl/fdiv_rshift_jam.sv
// Combinational right shift that ORs every bit shifted past the LSB into a
// sticky flag; shifts at or beyond CAP push the whole word into sticky.
module fdiv_rshift_jam #(
    parameter int W    = 25,
    parameter int SH_W = 5,
    parameter int CAP  = 26
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] sh,
    output logic [W-1:0]    dout,
    output logic            sticky
);

    always_comb begin
        dout   = '0;
        sticky = |din;
        if (int'(sh) < CAP) begin
            dout   = din >> sh;
            sticky = |(din & ~({W{1'b1}} << sh));
        end
    end

endmodule

// File: rtl/fdiv_round_pack.sv
// Post-divide stage of the binary32 divider: normalise the 1.31 quotient,
// denormalise tiny results, round per rm and pack the result with fflags.
module fdiv_round_pack #(
    parameter int EXP_W     = fpu_pkg::EXP_W,
    parameter int SHIFT_CAP = fpu_pkg::SHIFT_CAP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_valid,
    input  logic [31:0]             div_quotient,
    input  logic [31:0]             div_remainder,
    input  logic                    op_sign,
    input  logic signed [EXP_W-1:0] op_exp,
    input  logic [1:0]              op_special,
    input  logic [1:0]              op_flags,
    input  logic [2:0]              rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [4:0]              out_flags,
    output logic                    overrun
);
    import fpu_pkg::*;

    localparam int SH_W = $clog2(SHIFT_CAP + 1);
    localparam logic signed [EXP_W:0] ONE_E = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] CAP_E = (EXP_W+1)'(SHIFT_CAP);

    function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return ~sign & (g | s);
            RM_RMM:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

    function automatic logic ovf_to_inf(input logic [2:0] mode, input logic sign);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign;
            RM_RUP:  return ~sign;
            default: return 1'b1;
        endcase
    endfunction

    logic                    vld_p1, vld_p2;
    logic                    adv, accept;

    logic signed [EXP_W:0]   e_ext_p0, e_norm_p0, sh_full_p0;
    logic [23:0]             mant_n_p0, mant_p0;
    logic                    g_n_p0, s_n_p0, g_p0, s_p0, tiny_p0;
    logic [SH_W-1:0]         sh_p0;
    logic [24:0]             jam_out;
    logic                    jam_sticky;
    logic [EXP_W-1:0]        exp_p0;

    logic                    sign_p1, g_p1, s_p1, tiny_p1;
    logic [23:0]             mant_p1;
    logic [EXP_W-1:0]        exp_p1;
    logic [1:0]              special_p1, flags_p1;
    logic [2:0]              rm_p1;

    logic                    rnd_inc, rnd_nx, rnd_of;
    logic [24:0]             rnd_mant;
    logic [EXP_W:0]          rnd_exp;
    logic [22:0]             rnd_frac;
    logic [31:0]             res_p1;
    logic [4:0]              fflags_p1;

    assign adv       = !vld_p2 || out_ready;
    assign accept    = div_valid && (!vld_p1 || adv);
    assign out_valid = vld_p2;

    // S0 -> S1: normalise quotient, denormalise when the biased exponent is not positive
    always_comb begin
        e_ext_p0 = {op_exp[EXP_W-1], op_exp};
        if (div_quotient[31]) begin
            mant_n_p0 = div_quotient[31:8];
            g_n_p0    = div_quotient[7];
            s_n_p0    = (|div_quotient[6:0]) | (|div_remainder);
            e_norm_p0 = e_ext_p0;
        end else begin
            mant_n_p0 = div_quotient[30:7];
            g_n_p0    = div_quotient[6];
            s_n_p0    = (|div_quotient[5:0]) | (|div_remainder);
            e_norm_p0 = e_ext_p0 - ONE_E;
        end
        tiny_p0    = (e_norm_p0 <= 0);
        sh_full_p0 = ONE_E - e_norm_p0;
        sh_p0      = (sh_full_p0 >= CAP_E) ? SH_W'(SHIFT_CAP) : sh_full_p0[SH_W-1:0];
    end

    fdiv_rshift_jam #(
        .W    (25),
        .SH_W (SH_W),
        .CAP  (SHIFT_CAP)
    ) u_jam (
        .din    ({mant_n_p0, g_n_p0}),
        .sh     (sh_p0),
        .dout   (jam_out),
        .sticky (jam_sticky)
    );

    always_comb begin
        mant_p0 = mant_n_p0;
        g_p0    = g_n_p0;
        s_p0    = s_n_p0;
        exp_p0  = e_norm_p0[EXP_W-1:0];
        if (tiny_p0) begin
            mant_p0 = jam_out[24:1];
            g_p0    = jam_out[0];
            s_p0    = s_n_p0 | jam_sticky;
            exp_p0  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (adv)
                vld_p1 <= 1'b0;
            if (div_valid && !accept)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sign_p1    <= op_sign;
            mant_p1    <= mant_p0;
            g_p1       <= g_p0;
            s_p1       <= s_p0;
            tiny_p1    <= tiny_p0;
            exp_p1     <= exp_p0;
            special_p1 <= op_special;
            flags_p1   <= op_flags;
            rm_p1      <= rm_legal(rm);
        end
    end

    // S1 -> S2: round, detect overflow, pack binary32 and fflags
    always_comb begin
        rnd_inc  = round_inc(rm_p1, sign_p1, mant_p1[0], g_p1, s_p1);
        rnd_mant = {1'b0, mant_p1} + {24'd0, rnd_inc};
        if (exp_p1 == '0)
            rnd_exp = {{EXP_W{1'b0}}, rnd_mant[23]};
        else
            rnd_exp = {1'b0, exp_p1} + {{EXP_W{1'b0}}, rnd_mant[24]};
        rnd_frac = rnd_mant[24] ? rnd_mant[23:1] : rnd_mant[22:0];
        rnd_nx   = g_p1 | s_p1;
        rnd_of   = (rnd_exp >= (EXP_W+1)'(255));

        fflags_p1        = '0;
        fflags_p1[FF_NV] = flags_p1[1];
        fflags_p1[FF_DZ] = flags_p1[0];
        case (special_p1)
            SP_NAN:  res_p1 = CANON_NAN;
            SP_INF:  res_p1 = {sign_p1, INF_MAG};
            SP_ZERO: res_p1 = {sign_p1, 31'd0};
            default: begin
                fflags_p1[FF_NX] = rnd_nx;
                fflags_p1[FF_UF] = tiny_p1 & rnd_nx;
                if (rnd_of) begin
                    fflags_p1[FF_OF] = 1'b1;
                    fflags_p1[FF_NX] = 1'b1;
                    res_p1 = {sign_p1, ovf_to_inf(rm_p1, sign_p1) ? INF_MAG : MAX_MAG};
                end else begin
                    res_p1 = {sign_p1, rnd_exp[7:0], rnd_frac};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2     <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_result <= res_p1;
                out_flags  <= fflags_p1;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_round_pack.sv
// Scoreboard bench for fdiv_round_pack: directed vectors push expected
// results; a negedge monitor pops and compares on every output handshake.
module tb_fdiv_round_pack;
    import fpu_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               div_valid;
    logic [31:0]        div_quotient, div_remainder;
    logic               op_sign;
    logic signed [9:0]  op_exp;
    logic [1:0]         op_special, op_flags;
    logic [2:0]         rm;
    logic               out_valid, out_ready, overrun;
    logic [31:0]        out_result;
    logic [4:0]         out_flags;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mon_idx = 0;

    always #5 clk = ~clk;

    fdiv_round_pack #(.EXP_W(10), .SHIFT_CAP(26)) dut (
        .clk           (clk),
        .reset         (reset),
        .div_valid     (div_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .op_sign       (op_sign),
        .op_exp        (op_exp),
        .op_special    (op_special),
        .op_flags      (op_flags),
        .rm            (rm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_flags     (out_flags),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h required none", out_result);
            end else begin
                mon_e = sb_q.pop_front();
                check($sformatf("result[%0d]", mon_idx), out_result, mon_e.res);
                check($sformatf("flags[%0d]", mon_idx), {27'd0, out_flags}, {27'd0, mon_e.flags});
                mon_idx++;
            end
        end
    end

    // Called at posedge+1; holds div_valid for exactly one cycle
    task automatic issue(input logic [31:0] q, input logic [31:0] r, input logic s,
                         input logic signed [9:0] e, input logic [1:0] sp, input logic [1:0] fl,
                         input logic [2:0] m, input logic [31:0] xres, input logic [4:0] xfl,
                         input bit push);
        div_valid     = 1'b1;
        div_quotient  = q;
        div_remainder = r;
        op_sign       = s;
        op_exp        = e;
        op_special    = sp;
        op_flags      = fl;
        rm            = m;
        if (push) sb_q.push_back({xres, xfl});
        @(posedge clk);
        #1;
        div_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        div_valid = 1'b0;
        div_quotient = '0;
        div_remainder = '0;
        op_sign = 1'b0;
        op_exp = '0;
        op_special = 2'b00;
        op_flags = 2'b00;
        rm = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", {27'd0, out_flags}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: captured at edge N, visible after edge N+1
        issue(32'hC000_0000, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h3FC0_0000, 5'b00000, 1);
        check("lat_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_n2", {31'd0, out_valid}, 32'd1);

        // Back-to-back directed vectors
        issue(32'h5555_5555, 1, 1'b0, 10'sd126, 2'b00, 2'b00, 3'd0, 32'h3EAA_AAAB, 5'b00001, 1);
        issue(32'h5555_5555, 1, 1'b0, 10'sd126, 2'b00, 2'b00, 3'd1, 32'h3EAA_AAAA, 5'b00001, 1);
        issue(32'h5555_5555, 1, 1'b1, 10'sd126, 2'b00, 2'b00, 3'd2, 32'hBEAA_AAAB, 5'b00001, 1);
        issue(32'h5555_5555, 1, 1'b0, 10'sd126, 2'b00, 2'b00, 3'd7, 32'h3EAA_AAAB, 5'b00001, 1);
        issue(32'hC000_0000, 0, 1'b0, 10'sd255, 2'b00, 2'b00, 3'd0, 32'h7F80_0000, 5'b00101, 1);
        issue(32'hC000_0000, 0, 1'b0, 10'sd255, 2'b00, 2'b00, 3'd1, 32'h7F7F_FFFF, 5'b00101, 1);
        issue(32'hC000_0000, 0, 1'b1, 10'sd255, 2'b00, 2'b00, 3'd3, 32'hFF7F_FFFF, 5'b00101, 1);
        issue(32'hC000_0000, 0, 1'b0, 10'sd255, 2'b00, 2'b00, 3'd3, 32'h7F80_0000, 5'b00101, 1);
        issue(32'h8000_0000, 0, 1'b0, 10'sd0,   2'b00, 2'b00, 3'd0, 32'h0040_0000, 5'b00000, 1);
        issue(32'h8000_0000, 0, 1'b0, -10'sd30, 2'b00, 2'b00, 3'd3, 32'h0000_0001, 5'b00011, 1);
        issue(32'hFFFF_FFFF, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h4000_0000, 5'b00001, 1);
        issue(32'hFFFF_FF80, 0, 1'b0, 10'sd0,   2'b00, 2'b00, 3'd0, 32'h0080_0000, 5'b00011, 1);
        issue(32'h8000_0080, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h3F80_0000, 5'b00001, 1);
        issue(32'h8000_0080, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd4, 32'h3F80_0001, 5'b00001, 1);
        issue(32'h0000_0000, 0, 1'b0, 10'sd0,   2'b01, 2'b10, 3'd0, 32'h7FC0_0000, 5'b10000, 1);
        issue(32'h0000_0000, 0, 1'b1, 10'sd0,   2'b10, 2'b01, 3'd0, 32'hFF80_0000, 5'b01000, 1);
        issue(32'h0000_0000, 0, 1'b1, 10'sd0,   2'b11, 2'b00, 3'd0, 32'h8000_0000, 5'b00000, 1);
        drain();

        // Full pipe: input accepted in the same cycle as the output handshake
        out_ready = 1'b0;
        issue(32'hC000_0000, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h3FC0_0000, 5'b00000, 1);
        issue(32'hFFFF_FFFF, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h4000_0000, 5'b00001, 1);
        out_ready = 1'b1;
        issue(32'h8000_0000, 0, 1'b0, 10'sd0,   2'b00, 2'b00, 3'd0, 32'h0040_0000, 5'b00000, 1);
        check("simul_overrun", {31'd0, overrun}, 32'd0);
        drain();

        // Stalled output: two results held, third pulse overruns
        out_ready = 1'b0;
        issue(32'h5555_5555, 1, 1'b0, 10'sd126, 2'b00, 2'b00, 3'd0, 32'h3EAA_AAAB, 5'b00001, 1);
        repeat (32) @(posedge clk);
        #1;
        issue(32'hC000_0000, 0, 1'b0, 10'sd255, 2'b00, 2'b00, 3'd0, 32'h7F80_0000, 5'b00101, 1);
        repeat (32) @(posedge clk);
        #1;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_result", out_result, 32'h3EAA_AAAB);
        check("stall_no_overrun", {31'd0, overrun}, 32'd0);
        issue(32'h5555_5555, 1, 1'b0, 10'sd126, 2'b00, 2'b00, 3'd1, 32'h0, 5'b0, 0);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("stall_hold", out_result, 32'h3EAA_AAAB);
        check("stall_flags_hold", {27'd0, out_flags}, 32'd1);
        out_ready = 1'b1;
        drain();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset with both stages full discards everything immediately
        out_ready = 1'b0;
        issue(32'hC000_0000, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h0, 5'b0, 0);
        issue(32'hFFFF_FFFF, 0, 1'b0, 10'sd127, 2'b00, 2'b00, 3'd0, 32'h0, 5'b0, 0);
        check("full_before_rst", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", out_result, 32'd0);
        check("midrst_flags", {27'd0, out_flags}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_empty", {31'd0, out_valid}, 32'd0);
        issue(32'h8000_0000, 0, 1'b0, -10'sd30, 2'b00, 2'b00, 3'd3, 32'h0000_0001, 5'b00011, 1);
        check("postrst_n1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("postrst_n2", {31'd0, out_valid}, 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
